// File: rtl/aes_spi_pkg.sv
// Shared definitions for the AES SPI slave front end: opcodes, frame states,
// status byte layout and the CRC-8 polynomial.
package aes_spi_pkg;

   localparam logic [1:0] OP_STATUS  = 2'b00;
   localparam logic [1:0] OP_LOADKEY = 2'b01;
   localparam logic [1:0] OP_ENCRYPT = 2'b10;
   localparam logic [1:0] OP_DECRYPT = 2'b11;

   // Encodings kept explicit so existing probes and waveform filters still decode them.
   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_CMD      = 4'd1,
      ST_KEY_RX   = 4'd2,
      ST_TXT_RX   = 4'd3,
      ST_STAT_TX  = 4'd4,
      ST_WAIT     = 4'd5,
      ST_RES_TX   = 4'd6,
      ST_DONE     = 4'd7,
      ST_DRAIN    = 4'd8,
      ST_ERR_HOLD = 4'd9
   } state_t;

   localparam int unsigned STAT_KEY_VALID = 7;
   localparam int unsigned STAT_BUSY      = 6;
   localparam int unsigned STAT_ERR       = 5;

   localparam logic [7:0] CRC8_POLY = 8'h07;

endpackage

// File: rtl/aes_spi_crc8.sv
// Bit-serial CRC-8 (MSB first, init 0) with synchronous clear and enable.
module aes_spi_crc8
   import aes_spi_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       en,
   input  logic       din,
   output logic [7:0] crc
);

   logic fb;
   assign fb = crc[7] ^ din;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         crc <= '0;
      else if (clr)
         crc <= '0;
      else if (en)
         crc <= {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
   end

endmodule

// File: rtl/aes_spi_slave_ctrl.sv
// SPI slave command front end for the AES key expansion / cipher / inverse cipher cores.
// Optional CRC-8 on result and key transfers when AES_SPI_CRC8_EN is defined.
module aes_spi_slave_ctrl
   import aes_spi_pkg::*;
#(
   parameter int NK      = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cs,
   input  logic               mosi,
   output logic               miso,
   output logic [32*NK-1:0]   key_out,
   output logic               key_valid,
   output logic [127:0]       text_out,
   output logic               core_start,
   output logic               core_decrypt,
   input  logic [127:0]       core_result,
   input  logic               core_done
);

   localparam int unsigned KEY_BITS = 32 * NK;
   localparam int unsigned SR_W     = (KEY_BITS > 128) ? KEY_BITS : 128;
   localparam int unsigned TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TLAST  = TW'(TIMEOUT - 1);
`ifdef AES_SPI_CRC8_EN
   localparam logic [8:0] RES_LAST  = 9'd136;
`else
   localparam logic [8:0] RES_LAST  = 9'd128;
`endif

   state_t          state;
   logic [8:0]      bcnt;
   logic [TW-1:0]   tcnt;
   logic [SR_W-2:0] sreg;
   logic [127:0]    res_sr;
   logic [7:0]      stat_byte;
   logic            err, drain_pend, dec_op;
   logic            busy, core_fin, tx_bit;

   assign busy     = (state == ST_WAIT) || drain_pend;
   assign core_fin = busy && (core_done || (tcnt == TLAST));

   always_comb begin
      stat_byte                 = '0;
      stat_byte[STAT_KEY_VALID] = key_valid;
      stat_byte[STAT_BUSY]      = busy;
      stat_byte[STAT_ERR]       = err;
   end

`ifdef AES_SPI_CRC8_EN
   logic       crc_clr, crc_en, crc_din;
   logic [7:0] crc_val, crc_rx;

   assign crc_clr = (state == ST_CMD) || (state == ST_WAIT);
   assign crc_en  = (!cs && state == ST_KEY_RX && bcnt < 9'(KEY_BITS)) ||
                    (state == ST_RES_TX && bcnt != '0 && bcnt <= 9'd128);
   assign crc_din = (state == ST_KEY_RX) ? mosi : res_sr[127];

   aes_spi_crc8 u_crc (
      .clk   (clk),
      .reset (reset),
      .clr   (crc_clr),
      .en    (crc_en),
      .din   (crc_din),
      .crc   (crc_val)
   );
`endif

   always_comb begin
      tx_bit = 1'b0;
      case (state)
         ST_STAT_TX: tx_bit = res_sr[127];
         ST_RES_TX: begin
            if (bcnt == '0)
               tx_bit = 1'b1;
            else if (bcnt <= 9'd128)
               tx_bit = res_sr[127];
`ifdef AES_SPI_CRC8_EN
            else
               tx_bit = crc_val[3'(9'd136 - bcnt)];
`endif
         end
         default: tx_bit = 1'b0;
      endcase
   end

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) miso <= 1'b0;
      else        miso <= tx_bit;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         bcnt         <= '0;
         tcnt         <= '0;
         sreg         <= '0;
         res_sr       <= '0;
         key_out      <= '0;
         key_valid    <= 1'b0;
         text_out     <= '0;
         core_start   <= 1'b0;
         core_decrypt <= 1'b0;
         err          <= 1'b0;
         drain_pend   <= 1'b0;
         dec_op       <= 1'b0;
`ifdef AES_SPI_CRC8_EN
         crc_rx       <= '0;
`endif
      end else begin
         core_start <= 1'b0;
         // The core is tracked independently of the frame so a new frame can run while it drains.
         if (busy) tcnt <= core_fin ? '0 : tcnt + 1'b1;
         else      tcnt <= '0;
         if (drain_pend && core_fin) drain_pend <= 1'b0;

         if (cs) begin
            bcnt <= '0;
            if (busy && !core_fin) begin
               state      <= ST_DRAIN;
               drain_pend <= 1'b1;
            end else
               state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE, ST_DRAIN: begin
                  sreg  <= {sreg[SR_W-3:0], mosi};
                  bcnt  <= 9'd1;
                  state <= ST_CMD;
               end
               ST_CMD: begin
                  sreg <= {sreg[SR_W-3:0], mosi};
                  bcnt <= bcnt + 9'd1;
                  if (bcnt == 9'd7) begin
                     bcnt <= '0;
                     case (sreg[6:5])
                        OP_STATUS: begin
                           res_sr <= {stat_byte, 120'd0};
                           state  <= ST_STAT_TX;
                        end
                        OP_LOADKEY: state <= ST_KEY_RX;
                        OP_ENCRYPT, OP_DECRYPT: begin
                           if (key_valid && !busy) begin
                              dec_op <= sreg[5];
                              state  <= ST_TXT_RX;
                           end else begin
                              err   <= 1'b1;
                              state <= ST_ERR_HOLD;
                           end
                        end
                     endcase
                  end
               end
               ST_KEY_RX: begin
                  bcnt <= bcnt + 9'd1;
                  if (bcnt == '0) key_valid <= 1'b0;
                  if (bcnt < 9'(KEY_BITS)) sreg <= {sreg[SR_W-3:0], mosi};
                  if (bcnt == 9'(KEY_BITS - 1)) key_out <= {sreg[KEY_BITS-2:0], mosi};
`ifdef AES_SPI_CRC8_EN
                  if (bcnt >= 9'(KEY_BITS)) crc_rx <= {crc_rx[6:0], mosi};
                  if (bcnt == 9'(KEY_BITS + 7)) begin
                     if ({crc_rx[6:0], mosi} == crc_val) begin
                        key_valid <= 1'b1;
                        err       <= 1'b0;
                     end else
                        err <= 1'b1;
                     state <= ST_DONE;
                  end
`else
                  if (bcnt == 9'(KEY_BITS - 1)) begin
                     key_valid <= 1'b1;
                     err       <= 1'b0;
                     state     <= ST_DONE;
                  end
`endif
               end
               ST_TXT_RX: begin
                  sreg <= {sreg[SR_W-3:0], mosi};
                  bcnt <= bcnt + 9'd1;
                  if (bcnt == 9'd127) begin
                     text_out     <= {sreg[126:0], mosi};
                     core_decrypt <= dec_op;
                     core_start   <= 1'b1;
                     bcnt         <= '0;
                     state        <= ST_WAIT;
                  end
               end
               ST_WAIT: begin
                  if (core_done) begin
                     res_sr <= core_result;
                     bcnt   <= '0;
                     state  <= ST_RES_TX;
                  end else if (core_fin)
                     state <= ST_ERR_HOLD;
               end
               ST_RES_TX: begin
                  bcnt <= bcnt + 9'd1;
                  if (bcnt != '0) res_sr <= {res_sr[126:0], 1'b0};
                  if (bcnt == RES_LAST) state <= ST_DONE;
               end
               ST_STAT_TX: begin
                  bcnt   <= bcnt + 9'd1;
                  res_sr <= {res_sr[126:0], 1'b0};
                  if (bcnt == 9'd7) begin
                     err   <= 1'b0;
                     state <= ST_DONE;
                  end
               end
               default: ;
            endcase
         end

         if (busy && !core_done && tcnt == TLAST) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_aes_spi_slave_ctrl.sv
// Self-checking bench for aes_spi_slave_ctrl: SPI master tasks, core model and result scoreboard.
module tb_aes_spi_slave_ctrl;

   localparam int NK = 4;
   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] TX3 = 128'hffffffff00000000a5a5a5a55a5a5a5a;
   localparam logic [127:0] RX3 = 128'h00000000ffffffff5a5a5a5aa5a5a5a5;

   logic          clk = 1'b0, reset = 1'b0, cs = 1'b1, mosi = 1'b0;
   logic          miso, key_valid, core_start, core_decrypt;
   logic [127:0]  key_out, text_out;
   logic [127:0]  core_result = '0;
   logic          core_done = 1'b0;

   int unsigned   n_pass = 0, n_total = 0;
   int unsigned   start_cnt = 0, done_cnt = 0;
   int            core_lat = 40, busy_left = 0;
   bit            core_hang = 1'b0, pend = 1'b0;
   logic          last_dec = 1'b0;
   logic [127:0]  last_txt = '0;

   logic [127:0]  exp_q[$];
   logic [7:0]    stat_q[$];

   typedef struct {
      logic [7:0]   opb;
      logic [127:0] txt;
      logic [127:0] res;
      logic         dec;
      int           lat;
   } vec_t;
   vec_t vecs[3];

   always #5 clk = ~clk;

   aes_spi_slave_ctrl #(.NK(NK), .TIMEOUT(1024)) dut (
      .clk          (clk),
      .reset        (reset),
      .cs           (cs),
      .mosi         (mosi),
      .miso         (miso),
      .key_out      (key_out),
      .key_valid    (key_valid),
      .text_out     (text_out),
      .core_start   (core_start),
      .core_decrypt (core_decrypt),
      .core_result  (core_result),
      .core_done    (core_done)
   );

   function automatic logic [127:0] core_fn(input logic dec, input logic [127:0] t);
      if (!dec && t == PT) return CT;
      if (dec && t == CT)  return PT;
      return ~t;
   endfunction

   function automatic logic [7:0] crc8(input logic [127:0] d);
      logic [7:0] c;
      logic       fb;
      c = '0;
      for (int i = 127; i >= 0; i--) begin
         fb = c[7] ^ d[i];
         c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return c;
   endfunction

   // Core model: done a programmable number of negedges after the start pulse.
   always @(negedge clk) begin
      core_done = 1'b0;
      if (core_start) begin
         start_cnt++;
         last_dec  = core_decrypt;
         last_txt  = text_out;
         busy_left = core_lat;
         pend      = !core_hang;
      end else if (pend) begin
         if (busy_left <= 1) begin
            core_done   = 1'b1;
            core_result = core_fn(last_dec, last_txt);
            pend        = 1'b0;
            done_cnt++;
         end else
            busy_left--;
      end
   end

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic xfer(input logic b, output logic r);
      @(negedge clk);
      cs   = 1'b0;
      mosi = b;
      #1 r = miso;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic r;
      for (int i = 7; i >= 0; i--) xfer(b[i], r);
   endtask

   task automatic cs_end();
      @(negedge clk);
      cs   = 1'b1;
      mosi = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_status(input logic [7:0] exp, input string nm);
      logic       r;
      logic [7:0] got, e;
      got = '0;
      stat_q.push_back(exp);
      send_byte(8'h00);
      for (int i = 0; i < 8; i++) begin
         xfer(1'b0, r);
         got = {got[6:0], r};
      end
      e = stat_q.pop_front();
      check(nm, 256'(got), 256'(e));
      cs_end();
   endtask

   task automatic do_crypt(input logic [7:0] opb, input logic [127:0] txt, input logic [127:0] exp,
                           input logic dec, input int lat, input string nm);
      logic         r, found;
      logic [127:0] got, e;
      logic [7:0]   cgot;
      int unsigned  s0;
      core_lat = lat;
      s0       = start_cnt;
      got      = '0;
      cgot     = '0;
      send_byte(opb);
      for (int i = 127; i >= 0; i--) xfer(txt[i], r);
      exp_q.push_back(exp);
      found = 1'b0;
      for (int n = 0; n < 400 && !found; n++) begin
         xfer(1'b0, r);
         if (r) found = 1'b1;
      end
      check({nm, " marker"}, 256'(found), 256'(1));
      for (int i = 0; i < 128; i++) begin
         xfer(1'b0, r);
         got = {got[126:0], r};
      end
      e = exp_q.pop_front();
      check({nm, " result"}, 256'(got), 256'(e));
`ifdef AES_SPI_CRC8_EN
      for (int i = 0; i < 8; i++) begin
         xfer(1'b0, r);
         cgot = {cgot[6:0], r};
      end
      check({nm, " crc"}, 256'(cgot), 256'(crc8(e)));
`endif
      cs_end();
      check({nm, " start pulses"}, 256'(start_cnt - s0), 256'(1));
      check({nm, " decrypt mode"}, 256'(last_dec), 256'(dec));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic        r;
      logic        last;
      int unsigned s0, d0, ones;

      vecs[0] = '{8'h80, PT,  CT,  1'b0, 40};
      vecs[1] = '{8'hC0, CT,  PT,  1'b1, 40};
      vecs[2] = '{8'hBF, TX3, RX3, 1'b0, 7};

      repeat (3) @(negedge clk);
      #1;
      check("reset miso", 256'(miso), 256'(0));
      check("reset key_valid", 256'(key_valid), 256'(0));
      check("reset key_out", 256'(key_out), 256'(0));
      check("reset text_out", 256'(text_out), 256'(0));
      check("reset start/decrypt", 256'({core_start, core_decrypt}), 256'(0));
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Encrypt without a key is rejected.
      s0 = start_cnt;
      send_byte(8'h80);
      for (int i = 0; i < 16; i++) xfer(1'b1, r);
      cs_end();
      check("nokey start pulses", 256'(start_cnt - s0), 256'(0));
      do_status(8'h20, "nokey status err");
      do_status(8'h00, "nokey status cleared");

      // Key load with key_valid timing on the final frame bit.
      send_byte(8'h40);
      for (int i = 127; i >= 1; i--) xfer(KEY[i], r);
`ifdef AES_SPI_CRC8_EN
      begin
         logic [7:0] kc;
         kc = crc8(KEY);
         xfer(KEY[0], r);
         for (int i = 7; i >= 1; i--) xfer(kc[i], r);
         last = kc[0];
      end
`else
      last = KEY[0];
`endif
      check("key_valid before last bit", 256'(key_valid), 256'(0));
      xfer(last, r);
      @(posedge clk);
      #1;
      check("key_valid after last bit", 256'(key_valid), 256'(1));
      check("key_out", 256'(key_out), 256'(KEY));
      cs_end();
      do_status(8'h80, "status after key");

      for (int i = 0; i < 3; i++)
         do_crypt(vecs[i].opb, vecs[i].txt, vecs[i].res, vecs[i].dec, vecs[i].lat,
                  $sformatf("vec%0d", i));

      // Abort during WAIT, then a frame while the core drains.
      core_lat = 300;
      s0 = start_cnt;
      d0 = done_cnt;
      send_byte(8'h80);
      for (int i = 127; i >= 0; i--) xfer(PT[i], r);
      for (int i = 0; i < 5; i++) xfer(1'b0, r);
      cs_end();
      do_status(8'hC0, "drain status busy");
      send_byte(8'h80);
      for (int i = 0; i < 8; i++) xfer(1'b0, r);
      cs_end();
      check("drain reject start pulses", 256'(start_cnt - s0), 256'(1));
      do_status(8'hE0, "drain status err");
      for (int n = 0; n < 800 && done_cnt == d0; n++) @(negedge clk);
      check("drain core_done seen", 256'(done_cnt - d0), 256'(1));
      repeat (3) @(negedge clk);
      do_status(8'h80, "status after drain");
      do_crypt(vecs[0].opb, vecs[0].txt, vecs[0].res, vecs[0].dec, vecs[0].lat, "after drain");

      // Core that never finishes.
      core_hang = 1'b1;
      s0 = start_cnt;
      ones = 0;
      send_byte(8'h80);
      for (int i = 127; i >= 0; i--) xfer(PT[i], r);
      for (int n = 0; n < 1040; n++) begin
         xfer(1'b0, r);
         if (r) ones++;
      end
      check("timeout no marker", 256'(ones), 256'(0));
      check("timeout start pulses", 256'(start_cnt - s0), 256'(1));
      cs_end();
      core_hang = 1'b0;
      do_status(8'hA0, "timeout status");
      do_status(8'h80, "timeout status cleared");

      // Asynchronous reset while the status byte is being shifted out.
      send_byte(8'h00);
      xfer(1'b0, r);
      check("status msb before reset", 256'(r), 256'(1));
      #2 reset = 1'b0;
      #1;
      check("async reset miso", 256'(miso), 256'(0));
      check("async reset key_valid", 256'(key_valid), 256'(0));
      check("async reset key_out", 256'(key_out), 256'(0));
      cs = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      do_status(8'h00, "status after reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/aes_spi_slave_ctrl.md
Name: aes_spi_slave_ctrl

Overview:
- Next-generation SPI slave front end for the AES cipher cores. Replaces the fixed-latency, encrypt-only, fixed-key-size serial slave.
- Commands are framed by an opcode byte: load key, encrypt, decrypt, status.
- Key size is parametrised (AES-128/192/256). The core is driven through a start/done handshake instead of a hard-coded wait count.
- Sits between the external SPI master and the KeyExpansion/Cipher/InvCipher datapath. clk is the SPI serial clock.

Parameters:
- NK, 4, key length in 32-bit words (4, 6 or 8); KEY_BITS = 32*NK.
- TIMEOUT, 1024, maximum clk cycles to wait for core_done before flagging an error.

Ports:
- clk  in  1  SPI serial clock; mosi sampled on posedge, miso updated on negedge.
- reset  in  1  asynchronous, active-low reset.
- cs  in  1  chip select, active low; a rising edge ends or aborts the frame.
- mosi  in  1  serial data in, MSB first.
- miso  out  1  serial data out, MSB first.
- key_out  out  KEY_BITS  cipher key to key expansion.
- key_valid  out  1  key_out holds a completely loaded key.
- text_out  out  128  block to the cipher core.
- core_start  out  1  one-cycle start pulse.
- core_decrypt  out  1  mode for the current operation: 1 = decrypt.
- core_result  in  128  core output; valid when core_done = 1.
- core_done  in  1  one-cycle completion pulse.

Behaviour:
- Reset (reset = 0, async): state IDLE, miso = 0, key_out = 0, key_valid = 0, text_out = 0, core_start = 0, core_decrypt = 0, err = 0, bit counter = 0.
- Frame begins at the first posedge with cs = 0. The first 8 bits form the opcode; bits [7:6] select the command, bits [5:0] are ignored.
  - 00 STATUS
  - 01 LOADKEY
  - 10 ENCRYPT
  - 11 DECRYPT
- Top-level states: IDLE → CMD → {KEY_RX, TXT_RX, STAT_TX} → WAIT → RES_TX → DONE. Additional states: DRAIN and ERR_HOLD.
- CMD: shift in 8 bits. On the 8th bit, branch as follows.
  - STATUS → STAT_TX.
  - LOADKEY → KEY_RX.
  - ENCRYPT or DECRYPT with key_valid = 1 and the core idle → TXT_RX.
  - ENCRYPT or DECRYPT otherwise → ERR_HOLD with err = 1.
- KEY_RX: shift in KEY_BITS bits. On the last bit, key_out is loaded, key_valid = 1, err = 0, then DONE.
  - key_valid drops to 0 at the first key bit, so a partially loaded key is never flagged valid.
- TXT_RX: shift in 128 bits.
  - On the last bit, text_out is loaded, core_decrypt is set from the opcode, and core_start = 1 for exactly the following posedge cycle.
  - Then WAIT.
- WAIT: miso = 0 each negedge.
  - On core_done: latch core_result, then RES_TX.
  - If TIMEOUT cycles elapse without core_done: err = 1, then ERR_HOLD.
- RES_TX: emit a marker bit 1, then 128 result bits MSB first. The master hunts for the first 1 after the text, which gives it variable-latency alignment.
  - After the last bit, go to DONE.
- STAT_TX: emit 8 bits {key_valid, busy, err, 5'b0}, then DONE. busy = state in WAIT or DRAIN. Reading status clears err after the byte is sent.
- DONE and ERR_HOLD: miso = 0. Further mosi bits are ignored until cs rises.
- cs rise in any state: the frame ends and all counters clear.
  - In WAIT, go to DRAIN.
  - Otherwise go to IDLE.
- DRAIN: wait for core_done (or timeout), discard the result, then IDLE.
  - A frame started during DRAIN accepts STATUS and LOADKEY.
  - ENCRYPT or DECRYPT during DRAIN sets err = 1 and goes to ERR_HOLD.
- A core_done pulse outside WAIT and DRAIN is ignored.
- Reset mid-frame: immediate return to reset values. The key is lost.
- Counters are wide enough for KEY_BITS = 256 and for TIMEOUT.

Optional Feature:
- Macro: AES_SPI_CRC8_EN.
- Defined: after the 128 result bits, RES_TX emits 8 more bits, CRC-8 (polynomial 0x07, init 0x00) over the 128 result bits, MSB first.
  - LOADKEY frames also accept a trailing CRC-8 byte over the key. On mismatch, key_valid stays 0 and err = 1.
- Undefined: no CRC bits are sent or expected. The frame ends after the result or key.

Decomposition:
- Shared package aes_spi_pkg holds:
  - opcode constants OP_STATUS, OP_LOADKEY, OP_ENCRYPT, OP_DECRYPT;
  - the state enum;
  - the status bit positions;
  - CRC8_POLY.
- One natural sub-module: aes_spi_crc8 (bit-serial CRC-8 with clear/enable), used only under AES_SPI_CRC8_EN.

Test Plan:
- LOADKEY, NK = 4, key 000102030405060708090a0b0c0d0e0f → key_out equals it; key_valid rises on the bit-136 posedge; STATUS returns 8'h80.
- ENCRYPT of 00112233445566778899aabbccddeeff, with the core model giving done 40 cycles after start → miso shows 0s, then marker 1, then 69c4e0d86a7b0430d8cdb78070b4c55a; core_start is exactly 1 cycle; core_decrypt = 0.
- DECRYPT of 69c4e0d8… → core_decrypt = 1; result 00112233…eeff returned.
- ENCRYPT before any key → no core_start; err = 1; STATUS returns 8'h20 and then err reads 0.
- cs rise during WAIT, then immediate ENCRYPT frame → STATUS shows busy = 1; ENCRYPT rejected with err = 1; after core_done, IDLE, and a new ENCRYPT succeeds.
- Core never asserts done → after 1024 cycles, err = 1 and busy = 0; async reset mid-frame clears key_valid and miso immediately.
